// File: rtl/amul_pkg.sv
// Shared types and helpers for the approximate-multiplier error monitor.
package amul_pkg;

  localparam int N_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Absolute difference; callers narrow the result to their product width.
  function automatic logic [63:0] err_dist(input logic [63:0] x, input logic [63:0] y);
    return (x > y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/amul_op_delay.sv
// Delay line for issued operand pairs so they line up with a pipelined multiplier's product.
module amul_op_delay #(
  parameter int N   = 8,
  parameter int LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  output logic [N-1:0] out_a,
  output logic [N-1:0] out_b,
  output logic         busy
);

  generate
    if (LAT == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk | rst;
      assign out_valid = in_valid;
      assign out_a     = in_a;
      assign out_b     = in_b;
      assign busy      = 1'b0;
    end else begin : g_pipe
      logic [LAT-1:0]        vld_pipe_q, vld_pipe_d;
      logic [LAT-1:0][N-1:0] a_pipe_q, a_pipe_d;
      logic [LAT-1:0][N-1:0] b_pipe_q, b_pipe_d;

      always_comb begin
        vld_pipe_d    = '0;
        a_pipe_d      = '0;
        b_pipe_d      = '0;
        vld_pipe_d[0] = in_valid;
        a_pipe_d[0]   = in_a;
        b_pipe_d[0]   = in_b;
        for (int i = 1; i < LAT; i++) begin
          vld_pipe_d[i] = vld_pipe_q[i-1];
          a_pipe_d[i]   = a_pipe_q[i-1];
          b_pipe_d[i]   = b_pipe_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_pipe_q <= '0;
          a_pipe_q   <= '0;
          b_pipe_q   <= '0;
        end else begin
          vld_pipe_q <= vld_pipe_d;
          a_pipe_q   <= a_pipe_d;
          b_pipe_q   <= b_pipe_d;
        end
      end

      assign out_valid = vld_pipe_q[LAT-1];
      assign out_a     = a_pipe_q[LAT-1];
      assign out_b     = b_pipe_q[LAT-1];
      // Any pair still in flight keeps the sweep from being declared done.
      assign busy      = |vld_pipe_q;
    end
  endgenerate

endmodule

// File: rtl/amul_err_monitor.sv
// Sweeps every operand pair through an external multiplier and scores its products
// against the exact product: error count, summed/max error distance and the max's operands.
module amul_err_monitor
  import amul_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int DUT_LAT = 0,
  parameter int SUM_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N-1:0]     op_a,
  output logic [N-1:0]     op_b,
  output logic             op_valid,
  input  logic [2*N-1:0]   prod_in,
  output logic             busy,
  output logic             done,
  output logic [2*N:0]     err_count,
  output logic [SUM_W-1:0] sum_ed,
  output logic [2*N-1:0]   max_ed,
  output logic [N-1:0]     max_a,
  output logic [N-1:0]     max_b
);

  localparam int PW = 2 * N;
  localparam int CW = PW + 1;
  localparam int AW = ((SUM_W > PW) ? SUM_W : PW) + 1;
  localparam logic [SUM_W-1:0] SUM_SAT = {SUM_W{1'b1}};

  state_e         state_q, state_d;
  logic [N-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic           op_valid_q, op_valid_d;
  logic           clr;

  logic           d_valid, dly_busy;
  logic [N-1:0]   d_a, d_b;

  logic           s1_valid_q, s1_valid_d;
  logic [N-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [PW-1:0]  s1_prod_q, s1_prod_d;

  logic [CW-1:0]    err_count_q, err_count_d;
  logic [SUM_W-1:0] sum_ed_q, sum_ed_d;
  logic [PW-1:0]    max_ed_q, max_ed_d;
  logic [N-1:0]     max_a_q, max_a_d, max_b_q, max_b_d;

  logic [PW-1:0]  exact, ed;
  logic [AW-1:0]  sum_ext;

  // Sweep sequencer: {a,b} counts as one 2N-bit index, b in the low half.
  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_valid_d = op_valid_q;
    clr        = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = SWEEP;
          op_a_d     = '0;
          op_b_d     = '0;
          op_valid_d = 1'b1;
          clr        = 1'b1;
        end
      end
      SWEEP: begin
        if (&{op_a_q, op_b_q}) begin
          state_d    = DRAIN;
          op_a_d     = '0;
          op_b_d     = '0;
          op_valid_d = 1'b0;
        end else begin
          {op_a_d, op_b_d} = {op_a_q, op_b_q} + PW'(1);
        end
      end
      DRAIN: begin
        if (!dly_busy && !s1_valid_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  amul_op_delay #(.N(N), .LAT(DUT_LAT)) u_dly (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (op_valid_q),
    .in_a      (op_a_q),
    .in_b      (op_b_q),
    .out_valid (d_valid),
    .out_a     (d_a),
    .out_b     (d_b),
    .busy      (dly_busy)
  );

  always_comb begin
    s1_valid_d = d_valid;
    s1_a_d     = d_a;
    s1_b_d     = d_b;
    s1_prod_d  = prod_in;
  end

  // Scoring stage: exact product and error distance, then accumulate.
  always_comb begin
    exact       = PW'(s1_a_q) * PW'(s1_b_q);
    ed          = PW'(err_dist(64'(s1_prod_q), 64'(exact)));
    sum_ext     = AW'(sum_ed_q) + AW'(ed);
    err_count_d = err_count_q;
    sum_ed_d    = sum_ed_q;
    max_ed_d    = max_ed_q;
    max_a_d     = max_a_q;
    max_b_d     = max_b_q;
    if (clr) begin
      err_count_d = '0;
      sum_ed_d    = '0;
      max_ed_d    = '0;
      max_a_d     = '0;
      max_b_d     = '0;
    end else if (s1_valid_q) begin
      if (ed != '0) err_count_d = err_count_q + CW'(1);
      sum_ed_d = (sum_ext > AW'(SUM_SAT)) ? SUM_SAT : sum_ext[SUM_W-1:0];
      // Strictly greater so ties keep the earliest pair in sweep order.
      if (ed > max_ed_q) begin
        max_ed_d = ed;
        max_a_d  = s1_a_q;
        max_b_d  = s1_b_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_valid_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_prod_q   <= '0;
      err_count_q <= '0;
      sum_ed_q    <= '0;
      max_ed_q    <= '0;
      max_a_q     <= '0;
      max_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_valid_q  <= op_valid_d;
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_prod_q   <= s1_prod_d;
      err_count_q <= err_count_d;
      sum_ed_q    <= sum_ed_d;
      max_ed_q    <= max_ed_d;
      max_a_q     <= max_a_d;
      max_b_q     <= max_b_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_valid  = op_valid_q;
  assign busy      = (state_q == SWEEP) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign err_count = err_count_q;
  assign sum_ed    = sum_ed_q;
  assign max_ed    = max_ed_q;
  assign max_a     = max_a_q;
  assign max_b     = max_b_q;

endmodule

// File: tb/tb_amul_err_monitor.sv
// Two monitors (combinational and 2-cycle multiplier) scored against a sweep-level model.
module tb_amul_err_monitor;

  localparam int N   = 4;
  localparam int NP  = 256;
  localparam int SW1 = 12;

  logic clk = 1'b0;
  logic rst, start;
  always #5 clk = ~clk;

  logic [3:0]  op_a0, op_b0, op_a1, op_b1;
  logic        op_v0, op_v1, busy0, busy1, done0, done1;
  logic [7:0]  prod0, prod1, r1, r2;
  logic [8:0]  err0, err1;
  logic [31:0] sum0;
  logic [11:0] sum1;
  logic [7:0]  max0, max1;
  logic [3:0]  ma0, mb0, ma1, mb1;

  int          mode;
  logic [7:0]  tbl [NP];

  int checks = 0;
  int errors = 0;

  // Product source: 0 exact, 1 zero, 2 lsb cleared, 3 exact xor random table
  function automatic logic [7:0] pf(int md, logic [3:0] a, logic [3:0] b, logic [7:0] x);
    logic [7:0] ex;
    ex = 8'(a) * 8'(b);
    case (md)
      0: return ex;
      1: return 8'd0;
      2: return ex & 8'hFE;
      default: return ex ^ x;
    endcase
  endfunction

  assign prod0 = pf(mode, op_a0, op_b0, tbl[{op_a0, op_b0}]);
  always @(posedge clk) begin
    r1 <= pf(mode, op_a1, op_b1, tbl[{op_a1, op_b1}]);
    r2 <= r1;
  end
  assign prod1 = r2;

  amul_err_monitor #(.N(N), .DUT_LAT(0), .SUM_W(32)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a0), .op_b(op_b0), .op_valid(op_v0),
    .prod_in(prod0), .busy(busy0), .done(done0), .err_count(err0), .sum_ed(sum0),
    .max_ed(max0), .max_a(ma0), .max_b(mb0));

  amul_err_monitor #(.N(N), .DUT_LAT(2), .SUM_W(SW1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a1), .op_b(op_b1), .op_valid(op_v1),
    .prod_in(prod1), .busy(busy1), .done(done1), .err_count(err1), .sum_ed(sum1),
    .max_ed(max1), .max_a(ma1), .max_b(mb1));

  // ---------------- behavioural model ----------------
  int     lat [2] = '{0, 2};
  longint satv [2] = '{64'hFFFF_FFFF, 64'd4095};
  bit     running [2];
  int     m [2];
  int     pre_cnt [2][NP+1];
  longint pre_sum [2][NP+1];
  int     pre_max [2][NP+1];
  int     pre_ma [2][NP+1];
  int     pre_mb [2][NP+1];

  // Metrics after the first j pairs of the sweep, for every j.
  task automatic build_model(int d);
    int cnt, mx, mxa, mxb, p, ex, e;
    longint sm;
    cnt = 0; sm = 0; mx = 0; mxa = 0; mxb = 0;
    pre_cnt[d][0] = 0; pre_sum[d][0] = 0; pre_max[d][0] = 0;
    pre_ma[d][0] = 0; pre_mb[d][0] = 0;
    for (int idx = 0; idx < NP; idx++) begin
      ex = (idx / 16) * (idx % 16);
      p  = int'(pf(mode, 4'(idx / 16), 4'(idx % 16), tbl[idx]));
      e  = (p > ex) ? p - ex : ex - p;
      if (e != 0) cnt++;
      sm = (sm + e > satv[d]) ? satv[d] : sm + e;
      if (e > mx) begin mx = e; mxa = idx / 16; mxb = idx % 16; end
      pre_cnt[d][idx+1] = cnt; pre_sum[d][idx+1] = sm; pre_max[d][idx+1] = mx;
      pre_ma[d][idx+1] = mxa; pre_mb[d][idx+1] = mxb;
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        running[d] = 1'b0;
        m[d] = 0;
      end else if (start && (!running[d] || m[d] >= NP + lat[d] + 2)) begin
        build_model(d);
        running[d] = 1'b1;
        m[d] = 0;
      end else if (running[d] && m[d] < 100000) begin
        m[d]++;
      end
    end
  end

  function automatic logic [79:0] pk(logic v, logic [3:0] a, logic [3:0] b, logic bz,
                                     logic dn, logic [8:0] ec, logic [31:0] s,
                                     logic [7:0] mx, logic [3:0] xa, logic [3:0] xb);
    return {12'd0, v, a, b, bz, dn, ec, s, mx, xa, xb};
  endfunction

  task automatic check(string nm, logic [79:0] act, logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  bit          chk_en = 1'b0;
  int          cj;
  logic        cv;
  logic [79:0] ce, ca;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        if (!running[d]) begin
          ce = '0;
        end else begin
          cj = m[d] - 1 - lat[d];
          if (cj < 0) cj = 0;
          if (cj > NP) cj = NP;
          cv = (m[d] < NP);
          ce = pk(cv, cv ? 4'(m[d] / 16) : 4'd0, cv ? 4'(m[d] % 16) : 4'd0,
                  m[d] < NP + lat[d] + 2, m[d] >= NP + lat[d] + 2,
                  9'(pre_cnt[d][cj]), 32'(pre_sum[d][cj]), 8'(pre_max[d][cj]),
                  4'(pre_ma[d][cj]), 4'(pre_mb[d][cj]));
        end
        if (d == 0) ca = pk(op_v0, op_a0, op_b0, busy0, done0, err0, sum0, max0, ma0, mb0);
        else        ca = pk(op_v1, op_a1, op_b1, busy1, done1, err1, {20'd0, sum1}, max1, ma1, mb1);
        check($sformatf("cycle_dut%0d", d), ca, ce);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n0, output int n1);
    n0 = -1; n1 = -1;
    for (int n = 1; n <= 2000 && (n0 < 0 || n1 < 0); n++) begin
      @(posedge clk); #1;
      if (done0 && n0 < 0) n0 = n;
      if (done1 && n1 < 0) n1 = n;
    end
    if (n0 < 0 || n1 < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: done0=%0b done1=%0b, required both high", done0, done1);
    end
  endtask

  task automatic fill_tbl();
    for (int i = 0; i < NP; i++)
      tbl[i] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(1, 5)) @(posedge clk);
    #1;
  endtask

  int n0, n1;

  initial begin
    rst = 1'b1; start = 1'b0; mode = 0;
    for (int i = 0; i < NP; i++) tbl[i] = 8'd0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_dut0", pk(op_v0, op_a0, op_b0, busy0, done0, err0, sum0, max0, ma0, mb0), '0);
    check("reset_dut1", pk(op_v1, op_a1, op_b1, busy1, done1, err1, {20'd0, sum1}, max1, ma1, mb1), '0);

    // exact products
    idle_gap(); mode = 0; pulse_start(); wait_done(n0, n1);
    check("t1_done_lat0", 80'(n0), 80'(258));
    check("t1_done_lat2", 80'(n1), 80'(260));
    check("t1_err0", 80'(err0), 80'(0));
    check("t1_sum0", 80'(sum0), 80'(0));
    check("t1_err1", 80'(err1), 80'(0));

    // all-zero products
    idle_gap(); mode = 1; pulse_start(); wait_done(n0, n1);
    check("t2_err0", 80'(err0), 80'(225));
    check("t2_sum0", 80'(sum0), 80'(14400));
    check("t2_max0", 80'({max0, ma0, mb0}), 80'({8'd225, 4'd15, 4'd15}));
    check("t2_sum1_sat", 80'(sum1), 80'(4095));
    check("t2_err1", 80'(err1), 80'(225));

    // lsb cleared
    idle_gap(); mode = 2; pulse_start(); wait_done(n0, n1);
    check("t3_err0", 80'(err0), 80'(64));
    check("t3_sum0", 80'(sum0), 80'(64));
    check("t3_max0", 80'({max0, ma0, mb0}), 80'({8'd1, 4'd1, 4'd1}));

    // random corruption
    for (int r = 0; r < 2; r++) begin
      idle_gap(); fill_tbl(); mode = 3; pulse_start(); wait_done(n0, n1);
    end

    // reset mid-sweep, then a clean resweep
    idle_gap(); mode = 0; pulse_start();
    repeat (99) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_abort_dut0", pk(op_v0, op_a0, op_b0, busy0, done0, err0, sum0, max0, ma0, mb0), '0);
    check("t5_abort_dut1", pk(op_v1, op_a1, op_b1, busy1, done1, err1, {20'd0, sum1}, max1, ma1, mb1), '0);
    idle_gap(); pulse_start(); wait_done(n0, n1);
    check("t5_done_lat0", 80'(n0), 80'(258));
    check("t5_err0", 80'(err0), 80'(0));

    // start ignored while busy; honoured from DONE
    idle_gap(); fill_tbl(); mode = 3; pulse_start();
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(10, 50)) @(posedge clk);
      #1;
      pulse_start();
    end
    wait_done(n0, n1);
    fill_tbl(); mode = 2; pulse_start();
    check("t6_clear", 80'({err0, sum0, max0, ma0, mb0}), 80'(0));
    wait_done(n0, n1);
    check("t6_done_lat2", 80'(n1), 80'(260));
    check("t6_err1", 80'(err1), 80'(64));

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
